// File: rtl/fft_input_loader_if.sv
// Write-port and frame-handshake bundle between the FFT input loader
// (master) and the BRAM / FFT controller side (slave).
interface fft_input_loader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int BRAM_WIDTH = 10
);
  logic                    wr_en;
  logic                    wr_bank;
  logic [BRAM_WIDTH-1:0]   wr_addr;
  logic [2*DATA_WIDTH-1:0] wr_data;
  logic                    frame_ready;
  logic                    frame_bank;
  logic                    frame_ack;
  logic                    overrun;

  modport master (
    output wr_en, wr_bank, wr_addr, wr_data,
    output frame_ready, frame_bank, overrun,
    input  frame_ack
  );

  modport slave (
    input  wr_en, wr_bank, wr_addr, wr_data,
    input  frame_ready, frame_bank, overrun,
    output frame_ack
  );
endinterface

// File: rtl/fft_input_loader.sv
// FFT input loader: decimates the I/Q stream by RATE, packs samples as {i,q}
// and writes each N-sample frame at bit-reversed addresses into one of two
// ping-pong BRAM banks, then posts the frame through a ready/ack handshake.
module fft_input_loader #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int RES        = 256,
  parameter int N          = 16,
  parameter int DATA_WIDTH = 8,
  parameter int BRAM_WIDTH = 10,
  parameter int RATE       = CLK_FREQ >> ($clog2(RES) + $clog2(N))
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] i_in,
  input  logic [DATA_WIDTH-1:0] q_in,
  fft_input_loader_if.master    bus
);

  localparam int L  = $clog2(N);
  localparam int CW = (RATE > 1) ? $clog2(RATE) : 1;

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t         state_reg;
  logic [CW-1:0]  cnt_reg;
  logic [L-1:0]   idx_reg;
  logic           last_reg;   // marks the write currently on the bus as sample N-1
  logic           tick;

  // Mirror the low L bits of the sample index to get its storage address.
  function automatic logic [L-1:0] bitrev(input logic [L-1:0] v);
    logic [L-1:0] r;
    for (int b = 0; b < L; b++) begin
      r[b] = v[L-1-b];
    end
    return r;
  endfunction

  // Decimation strobe: last cycle of each RATE-cycle sample period.
  always_comb begin
    tick = (cnt_reg == CW'(RATE - 1));
  end

  // Capture FSM, BRAM write port and frame handshake, all registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      idx_reg         <= '0;
      last_reg        <= 1'b0;
      bus.wr_en       <= 1'b0;
      bus.wr_bank     <= 1'b0;
      bus.wr_addr     <= '0;
      bus.wr_data     <= '0;
      bus.frame_ready <= 1'b0;
      bus.frame_bank  <= 1'b0;
      bus.overrun     <= 1'b0;
    end else begin
      bus.wr_en <= 1'b0;
      last_reg  <= 1'b0;

      // Completion of the frame's final write takes priority; an ack in the
      // same cycle frees the slot so the new frame can be posted at once.
      if (bus.wr_en && last_reg) begin
        if (!bus.frame_ready || bus.frame_ack) begin
          bus.frame_ready <= 1'b1;
          bus.frame_bank  <= bus.wr_bank;
          bus.wr_bank     <= ~bus.wr_bank;
        end else begin
          // Slot still occupied: drop this frame and keep writing the same
          // (non-pending) bank so the pending one is never touched.
          bus.overrun <= 1'b1;
        end
      end else if (bus.frame_ready && bus.frame_ack) begin
        bus.frame_ready <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          idx_reg <= '0;
          if (enable) begin
            state_reg <= FILL;
          end
        end
        FILL: begin
          if (!enable) begin
            // Abandon the partial frame; bank and pending frame are kept.
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
          end else if (tick) begin
            cnt_reg     <= '0;
            bus.wr_en   <= 1'b1;
            bus.wr_data <= {i_in, q_in};
            bus.wr_addr <= BRAM_WIDTH'(bitrev(idx_reg));
            last_reg    <= (idx_reg == L'(N - 1));
            idx_reg     <= idx_reg + 1'b1;   // N is a power of two, wraps naturally
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed testbench for fft_input_loader (N=8, RATE=4, DATA_WIDTH=8).
module tb_fft_input_loader;

  localparam int N  = 8;
  localparam int RT = 4;
  localparam int DW = 8;
  localparam int BW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [DW-1:0] i_in = '0;
  logic [DW-1:0] q_in = '1;

  fft_input_loader_if #(.DATA_WIDTH(DW), .BRAM_WIDTH(BW)) bus ();

  fft_input_loader #(
    .N(N), .DATA_WIDTH(DW), .BRAM_WIDTH(BW), .RATE(RT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .i_in(i_in), .q_in(q_in), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0]   addr;
    logic [2*DW-1:0] data;
    logic            bank;
    int              cyc;
  } wr_t;

  typedef struct {
    logic [DW-1:0] i;
    logic [DW-1:0] q;
    logic [BW-1:0] addr;
  } vec_t;

  wr_t  wq[$];
  vec_t vec[N];
  int   wcnt = 0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Write monitor: logs each BRAM write and steers i/q to the sample index.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      wcnt = 0;
    end else if (bus.wr_en) begin
      wq.push_back('{addr: bus.wr_addr, data: bus.wr_data, bank: bus.wr_bank, cyc: cyc});
      wcnt = wcnt + 1;
    end
    i_in = DW'(wcnt % N);
    q_in = ~i_in;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_q(input int n);
    int t = 0;
    while (wq.size() < n && t < 300) begin
      step();
      t++;
    end
    if (wq.size() < n) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d writes expected %0d", wq.size(), n);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wr_en"},       32'(bus.wr_en), 0);
    check({tag, "_wr_bank"},     32'(bus.wr_bank), 0);
    check({tag, "_wr_addr"},     32'(bus.wr_addr), 0);
    check({tag, "_wr_data"},     32'(bus.wr_data), 0);
    check({tag, "_frame_ready"}, 32'(bus.frame_ready), 0);
    check({tag, "_frame_bank"},  32'(bus.frame_bank), 0);
    check({tag, "_overrun"},     32'(bus.overrun), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    wq.delete();
    rst_n = 1'b1;
  endtask

  // Compare the eight writes starting at wq[base] against the vector table.
  task automatic check_frame(input int base, input logic bank, input bit chk_data);
    for (int k = 0; k < N; k++) begin
      if (base + k < wq.size()) begin
        $display("write %0d: addr=%0d data=%04h bank=%0d cyc=%0d",
                 base + k, wq[base+k].addr, wq[base+k].data, wq[base+k].bank, wq[base+k].cyc);
        check($sformatf("addr_%0d", base + k), 32'(wq[base+k].addr), 32'(vec[k].addr));
        check($sformatf("bank_%0d", base + k), 32'(wq[base+k].bank), 32'(bank));
        if (chk_data)
          check($sformatf("data_%0d", base + k), 32'(wq[base+k].data), 32'({vec[k].i, vec[k].q}));
        if (k > 0)
          check($sformatf("interval_%0d", base + k), 32'(wq[base+k].cyc - wq[base+k-1].cyc), RT);
      end
    end
  endtask

  initial begin
    // Vector table: sample k carries i=k, q=~k and lands at bitrev3(k).
    vec[0] = '{8'h00, 8'hFF, 10'd0};
    vec[1] = '{8'h01, 8'hFE, 10'd4};
    vec[2] = '{8'h02, 8'hFD, 10'd2};
    vec[3] = '{8'h03, 8'hFC, 10'd6};
    vec[4] = '{8'h04, 8'hFB, 10'd1};
    vec[5] = '{8'h05, 8'hFA, 10'd5};
    vec[6] = '{8'h06, 8'hF9, 10'd3};
    vec[7] = '{8'h07, 8'hF8, 10'd7};
    bus.frame_ack = 1'b0;

    // Reset state
    step(); step();
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Reset mid-frame after three writes
    enable = 1'b1;
    wait_q(3);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    step(); step();
    wq.delete();
    rst_n = 1'b1;

    // Bit-reversed first frame into bank 0
    wait_q(8);
    check("ready_before_complete", 32'(bus.frame_ready), 0);
    step();
    check_frame(0, 1'b0, 1'b1);
    check("f1_ready", 32'(bus.frame_ready), 1);
    check("f1_bank",  32'(bus.frame_bank), 0);
    check("f1_wr_bank", 32'(bus.wr_bank), 1);
    check("f1_overrun", 32'(bus.overrun), 0);

    // Ping-pong: ack five cycles later, second frame goes to bank 1
    for (int c = 0; c < 4; c++) step();
    bus.frame_ack = 1'b1;
    step();
    bus.frame_ack = 1'b0;
    check("ack_clears_ready", 32'(bus.frame_ready), 0);
    wait_q(16);
    step();
    check_frame(8, 1'b1, 1'b1);
    check("f2_ready", 32'(bus.frame_ready), 1);
    check("f2_bank",  32'(bus.frame_bank), 1);
    check("f2_overrun", 32'(bus.overrun), 0);
    check("f2_wr_bank", 32'(bus.wr_bank), 0);

    // Overrun: no ack, second frame dropped, third frame reuses bank 1
    do_reset();
    wait_q(8);
    step();
    check("ov_f1_ready", 32'(bus.frame_ready), 1);
    wait_q(16);
    step();
    check_frame(8, 1'b1, 1'b0);
    check("ov_overrun", 32'(bus.overrun), 1);
    check("ov_frame_bank", 32'(bus.frame_bank), 0);
    check("ov_ready", 32'(bus.frame_ready), 1);
    wait_q(17);
    check("ov_f3_bank", 32'(wq[16].bank), 1);
    check("ov_f3_addr", 32'(wq[16].addr), 0);
    check("ov_sticky", 32'(bus.overrun), 1);

    // Coincident ack and completion
    do_reset();
    wait_q(8);
    step();
    check("co_f1_bank", 32'(bus.frame_bank), 0);
    wait_q(16);
    bus.frame_ack = 1'b1;
    step();
    bus.frame_ack = 1'b0;
    check("co_ready", 32'(bus.frame_ready), 1);
    check("co_bank", 32'(bus.frame_bank), 1);
    check("co_overrun", 32'(bus.overrun), 0);
    step();
    check("co_ready_held", 32'(bus.frame_ready), 1);

    // Enable drop after five writes of frame 3, then re-enable
    wait_q(21);
    enable = 1'b0;
    for (int c = 0; c < 8; c++) step();
    check("drop_no_writes", 32'(wq.size()), 21);
    enable = 1'b1;
    wait_q(22);
    check("drop_bank_before", 32'(wq[20].bank), 0);
    check("drop_addr", 32'(wq[21].addr), 0);
    check("drop_bank", 32'(wq[21].bank), 0);
    check("drop_pending", 32'(bus.frame_ready), 1);
    check("drop_pending_bank", 32'(bus.frame_bank), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
